// File: rtl/full_adder_bh.sv
// full_adder_bh: registered WIDTH-bit adder, {cout,s} = a + b + c, one-cycle latency.
// Ports: clk, rst (sync, active-high), a/b/c/in_valid in; s/cout/out_valid out.
// Optional FA_STATUS_EN adds registered zero (s==0 && cout==0) and ovf (signed overflow).
module full_adder_bh #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
`ifdef FA_STATUS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int MSB = WIDTH - 1;

  // Full WIDTH+1 bit sum so the carry is never lost before the split.
  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum[MSB:0];
        cout <= sum[WIDTH];
      end
    end
  end

`ifdef FA_STATUS_EN
  // Status flags follow the result registers: same enable, same reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (in_valid) begin
      zero <= (sum == '0);
      ovf  <= (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_bh.sv
// tb_full_adder_bh: scoreboard bench for full_adder_bh at WIDTH 1, 4 and 8.
// Expected {ovf,zero,cout,s} pushed at issue, popped by per-DUT monitors.
module tb_full_adder_bh;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [0:0] a1, b1, s1;
  logic       c1, v1, co1, ov1;
  logic [3:0] a4, b4, s4;
  logic       c4, v4, co4, ov4;
  logic [7:0] a8, b8, s8;
  logic       c8, v8, co8, ov8;
`ifdef FA_STATUS_EN
  logic z1, f1, z4, f4, z8, f8;
`endif

  int total = 0;
  int bad = 0;

  logic [3:0]  q1[$];
  logic [6:0]  q4[$];
  logic [10:0] q8[$];

  logic [3:0]  e1, x1;
  logic [6:0]  e4, x4;
  logic [10:0] e8, x8;

  full_adder_bh #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .s(s1), .cout(co1), .out_valid(ov1)
`ifdef FA_STATUS_EN
    , .zero(z1), .ovf(f1)
`endif
  );

  full_adder_bh #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .in_valid(v4),
    .s(s4), .cout(co4), .out_valid(ov4)
`ifdef FA_STATUS_EN
    , .zero(z4), .ovf(f4)
`endif
  );

  full_adder_bh #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(v8),
    .s(s8), .cout(co8), .out_valid(ov8)
`ifdef FA_STATUS_EN
    , .zero(z8), .ovf(f8)
`endif
  );

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic spurious(input string n);
    total++;
    bad++;
    $display("FAIL %s out_valid with empty scoreboard got=1 want=0", n);
  endtask

  // Monitors: status bits are masked off when the feature is absent.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) spurious("w1");
      else begin
        e1 = q1.pop_front();
`ifdef FA_STATUS_EN
        x1 = {f1, z1, co1, s1};
`else
        x1 = {2'b00, co1, s1};
        e1[3:2] = 2'b00;
`endif
        chk("w1_result", 16'(x1), 16'(e1));
      end
    end
  end

  always @(negedge clk) begin
    if (ov4 === 1'b1) begin
      if (q4.size() == 0) spurious("w4");
      else begin
        e4 = q4.pop_front();
`ifdef FA_STATUS_EN
        x4 = {f4, z4, co4, s4};
`else
        x4 = {2'b00, co4, s4};
        e4[6:5] = 2'b00;
`endif
        chk("w4_result", 16'(x4), 16'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) spurious("w8");
      else begin
        e8 = q8.pop_front();
`ifdef FA_STATUS_EN
        x8 = {f8, z8, co8, s8};
`else
        x8 = {2'b00, co8, s8};
        e8[10:9] = 2'b00;
`endif
        chk("w8_result", 16'(x8), 16'(e8));
      end
    end
  end

  task automatic put1(input logic a, b, c, input logic [3:0] e);
    a1 = a; b1 = b; c1 = c; v1 = 1'b1;
    q1.push_back(e);
  endtask

  task automatic put4(input logic [3:0] a, b, input logic c,
                      input logic [6:0] e);
    a4 = a; b4 = b; c4 = c; v4 = 1'b1;
    q4.push_back(e);
  endtask

  task automatic put8(input logic [7:0] a, b, input logic c,
                      input logic [10:0] e);
    a8 = a; b8 = b; c8 = c; v8 = 1'b1;
    q8.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
  endtask

  task automatic chk_idle(input string n);
    chk({n, "_ov1"}, 16'(ov1), 16'd0);
    chk({n, "_w1"}, 16'({co1, s1}), 16'd0);
    chk({n, "_ov4"}, 16'(ov4), 16'd0);
    chk({n, "_w4"}, 16'({co4, s4}), 16'd0);
    chk({n, "_ov8"}, 16'(ov8), 16'd0);
    chk({n, "_w8"}, 16'({co8, s8}), 16'd0);
`ifdef FA_STATUS_EN
    chk({n, "_st8"}, 16'({f8, z8}), 16'd0);
`endif
  endtask

  // Expected words are {ovf, zero, cout, s}.
  initial begin
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b1; v4 = 1'b1;
    a8 = 8'd1; b8 = 8'd1; c8 = 1'b1; v8 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle("reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;

    put1(0, 0, 0, 4'b0100); tick;
    put1(0, 0, 1, 4'b1001); tick;
    put1(0, 1, 0, 4'b0001); tick;
    put1(0, 1, 1, 4'b0010); tick;
    put1(1, 0, 0, 4'b0001); tick;
    put1(1, 0, 1, 4'b0010); tick;
    put1(1, 1, 0, 4'b1010); tick;
    put1(1, 1, 1, 4'b0011); tick;

    put1(1, 0, 0, 4'b0001); tick;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
    tick;
    @(negedge clk);
    chk("hold_ov", 16'(ov1), 16'd0);
    chk("hold_val", 16'({co1, s1}), 16'b01);
    tick;

    put8(8'hFF, 8'h00, 1'b1, {1'b0, 1'b0, 1'b1, 8'h00}); tick;
    put8(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 1'b0, 8'h80}); tick;
    put8(8'h00, 8'h00, 1'b0, {1'b0, 1'b1, 1'b0, 8'h00}); tick;
    put8(8'h80, 8'h80, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00}); tick;
    put8(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b0, 1'b1, 8'hFF}); tick;

    put4(4'd3, 4'd4, 1'b0, 7'b00_0_0111); tick;
    put4(4'd15, 4'd15, 1'b1, 7'b00_1_1111); tick;
    put4(4'd8, 4'd8, 1'b0, 7'b10_1_0000); tick;

    put4(4'd5, 4'd5, 1'b0, 7'b10_0_1010);
    put8(8'h12, 8'h34, 1'b1, {1'b0, 1'b0, 1'b0, 8'h47});
    tick;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    a4 = 4'd1; b4 = 4'd1; c4 = 1'b0; v4 = 1'b1;
    a8 = 8'd1; b8 = 8'd1; c8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    chk_idle("rst_prio");

    put1(1, 1, 1, 4'b0011);
    put4(4'd9, 4'd6, 1'b1, 7'b00_1_0000);
    tick;
    tick;
    repeat (3) @(negedge clk);

    chk("q1_drained", 16'(q1.size()), 16'd0);
    chk("q4_drained", 16'(q4.size()), 16'd0);
    chk("q8_drained", 16'(q8.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder_bh.md
Name: full_adder_bh

Overview:
Registered, parameterizable-width binary full adder, behavioural style. Computes a + b + c and presents sum and carry-out one clock after a qualified input. Used as a basic arithmetic leaf cell in the Basys3 digital-circuit designs. At WIDTH=1 it is the classic 1-bit full adder: sum = a^b^c, carry = majority(a,b,c).

Parameters:
WIDTH, 1, operand width in bits for a, b and s; c and cout are always 1 bit.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
c  input  1  carry-in
in_valid  input  1  qualifies a/b/c for the current cycle
s  output  WIDTH  registered sum, bits [WIDTH-1:0] of a+b+c
cout  output  1  registered carry-out, bit WIDTH of a+b+c
out_valid  output  1  high for one cycle when s/cout hold a new result

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. rst is sampled only on the rising edge of clk.
- Reset: on a rising edge with rst=1, s=0, cout=0, out_valid=0. rst has priority over in_valid on the same edge.
- Arithmetic: {cout,s} = zero-extended a + zero-extended b + c, computed at WIDTH+1 bits. No truncation before the final split.
- Latency: fixed at 1 cycle. in_valid=1 at edge N produces s/cout from that edge's a/b/c, with out_valid=1, after edge N.
- When in_valid=0 at an edge: s and cout hold their previous values, and out_valid=0.
- Back-to-back: in_valid may stay high on every cycle, giving one result per cycle. There is no backpressure and no stall.
- Boundaries:
  - All-ones operands with c=1 give s = all-ones and cout=1.
  - All-zero operands give s=0 and cout=0.
  - When the sum overflows, the result wraps into s and the lost bit appears on cout.
- Reset mid-stream: a result pending at the reset edge is discarded. The first post-reset out_valid comes from the first in_valid=1 edge with rst=0.
- No X propagation from a held state: outputs are always driven from registers.

Optional Feature:
Macro FA_STATUS_EN.
- Defined: adds two outputs, both registered alongside s/cout, cleared by rst, and held when in_valid=0.
  - zero (1 bit): 1 when s==0 and cout==0.
  - ovf (1 bit): signed overflow, meaning a[MSB]==b[MSB] and s[MSB]!=a[MSB].
- Not defined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1,b=1,c=1,in_valid=1 -> s=0, cout=0, out_valid=0 throughout.
- Exhaustive at WIDTH=1: apply {a,b,c}=000..111, one per cycle with in_valid=1.
  - Expected {cout,s} one cycle later: 00,01,01,10,01,10,10,11.
  - out_valid=1 on each of those 8 cycles.
- Hold: a=1,b=0,c=0,in_valid=1, then in_valid=0 with a=1,b=1,c=1 -> s=1, cout=0 hold, out_valid drops to 0.
- Width boundary at WIDTH=8:
  - a=8'hFF, b=8'h00, c=1 -> s=8'h00, cout=1.
  - a=8'h7F, b=8'h01, c=0 -> s=8'h80, cout=0; with FA_STATUS_EN, ovf=1, zero=0.
- Reset priority: rst=1 and in_valid=1 on the same edge with a=1,b=1,c=0 -> s=0, cout=0, out_valid=0 after that edge.
- Streaming at WIDTH=4: (3,4,0), (15,15,1), (8,8,0) on consecutive cycles -> {cout,s} = (0,7), (1,15), (1,0) on consecutive cycles.
